// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running binary counter bus.
// Each enabled sample is checked against prev+1 (mod 2^WIDTH). A small
// FSM (IDLE -> SYNC -> LOCK) acquires lock after SYNC_LEN good steps and
// drops it after ERR_LIMIT consecutive bad steps. While locked, errors
// and max->0 wraps are pulsed and counted.
// Optional feature: define COUNT_CHK_DOWN_EN to add a 'dir' input that
// selects down-count checking (dir=1) with the wrap taken as 0->all-ones.
module count_seq_checker #(
    parameter int WIDTH     = 2,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_LIMIT = 3,
    parameter int WRAP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
`ifdef COUNT_CHK_DOWN_EN
    input  logic              dir,
`endif
    output logic              locked,
    output logic              err_pulse,
    output logic [7:0]        err_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [1:0]        state
);

    localparam int GR_W = $clog2(SYNC_LEN + 1);
    localparam int BR_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        LOCK = 2'b10
    } st_t;

    st_t               state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [GR_W-1:0]   good_run_q, good_run_d;
    logic [BR_W-1:0]   bad_run_q, bad_run_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              locked_q, locked_d;

    logic [WIDTH-1:0]  expected;
    logic              good;
    logic              wrap_hit;
    logic [GR_W-1:0]   gr_inc;
    logic [BR_W-1:0]   br_inc;
    logic              sync_done;
    logic              err_done;

    // Step classification: expected next value and wrap boundary for the
    // active count direction.
    always_comb begin
`ifdef COUNT_CHK_DOWN_EN
        if (dir) begin
            expected = prev_q - WIDTH'(1);
            wrap_hit = (prev_q == '0) && (count_in == '1);
        end else begin
            expected = prev_q + WIDTH'(1);
            wrap_hit = (prev_q == '1) && (count_in == '0);
        end
`else
        expected = prev_q + WIDTH'(1);
        wrap_hit = (prev_q == '1) && (count_in == '0);
`endif
        good      = (count_in == expected);
        gr_inc    = good_run_q + GR_W'(1);
        br_inc    = bad_run_q + BR_W'(1);
        sync_done = (gr_inc == GR_W'(SYNC_LEN));
        err_done  = (br_inc == BR_W'(ERR_LIMIT));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; the unused encoding falls back to IDLE on the next
    // edge even when sampling is disabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = SYNC;
            SYNC: if (en && good && sync_done) state_d = LOCK;
            LOCK: if (en && !good && err_done) state_d = SYNC;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: run counters, event counters and pulses for this sample.
    always_comb begin
        prev_d       = prev_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        locked_d     = (state_d == LOCK);
        if (en) begin
            case (state_q)
                IDLE: begin
                    prev_d     = count_in;
                    good_run_d = '0;
                end
                SYNC: begin
                    prev_d = count_in;
                    if (good) begin
                        good_run_d = gr_inc;
                        if (sync_done) begin
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                LOCK: begin
                    prev_d = count_in;
                    if (good) begin
                        bad_run_d = '0;
                        if (wrap_hit) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        bad_run_d = br_inc;
                        if (err_done) begin
                            bad_run_d  = '0;
                            good_run_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            locked_q     <= locked_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign state      = state_q;

endmodule
